// File: rtl/shift_add_multiplier_if.sv
// Handshake and data bundle for the shift-add multiplier.
// The requester drives start and the operands; the multiplier returns busy, done and product.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier using shift-and-add, one partial product per clock.
// The accumulator A carries one extra bit so an all-ones by all-ones product stays exact.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | WIDTH add/shift steps in progress, busy high
// DONE  | one-cycle done pulse; a start here begins the next operation back-to-back
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  shift_add_multiplier_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;

  // One add/shift step: conditionally add M, then shift {S, Q} right with zero fill.
  always_comb begin
    sum    = a_reg + (q_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});
    a_next = {1'b0, sum[WIDTH:1]};
    q_next = {sum[0], q_reg[WIDTH-1:1]};
  end

  // Control FSM and datapath registers; outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      m_reg       <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            m_reg    <= bus.multiplicand;
            q_reg    <= bus.multiplier;
            a_reg    <= '0;
            cnt      <= CW'(WIDTH);
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt - CW'(1);
          // Last step: publish the freshly shifted result so it is valid with done.
          if (cnt == CW'(1)) begin
            bus.product <= {a_next[WIDTH-1:0], q_next};
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: a driver pushes expected products computed
// with plain multiplication, and an independent monitor pops and checks on every done.
module tb_shift_add_multiplier;
  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();
  shift_add_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t           sb[$];
  int             n_cmp    = 0;
  int             n_err    = 0;
  int             cyc      = 0;
  int             done_cnt = 0;
  int             issued   = 0;
  int             busy_run = 0;
  logic [2*W-1:0] prod_hold = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issue an operation that the bench knows will be accepted at the next rising edge.
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
    exp_t e;
    e.prod = {{W{1'b0}}, m};
    e.prod = e.prod * {{W{1'b0}}, q};
    e.acc  = cyc + 1;
    sb.push_back(e);
    issued++;
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
  endtask

  // Returns at the falling edge of the cycle in which done is high.
  task automatic wait_done();
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_done: timeout after %0d cycles", 3 * W);
  endtask

  // Monitor: product/latency/busy-length on done, product stability while busy.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_run = 0;
      end else if (bus.busy) begin
        busy_run++;
        check("hold_in_run", bus.product, prod_hold);
      end else begin
        if (bus.done) begin
          done_cnt++;
          check("busy_len", busy_run, W);
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done with product %0h, required no done", bus.product);
          end else begin
            e = sb.pop_front();
            check("product", bus.product, e.prod);
            check("latency", cyc - e.acc, W);
            prod_hold = e.prod;
          end
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    logic [W-1:0] rm, rq;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_product", bus.product, 0);
    rst = 1'b1;

    // First edge after reset release accepts; then basic, max, zero-operand cases.
    issue(16'd3, 16'd5);            wait_done();
    repeat (2) @(negedge clk);
    issue(16'hFFFF, 16'hFFFF);      wait_done();
    issue(16'h1234, 16'h0000);      wait_done();
    issue(16'h0000, 16'hABCD);      wait_done();
    repeat (2) @(negedge clk);

    // Start during RUN is ignored: only one product, one done.
    issue(16'h0055, 16'h0066);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.multiplicand = 16'd7; bus.multiplier = 16'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    repeat (W + 4) @(negedge clk);

    // Back-to-back: start held during the done cycle.
    issue(16'h0010, 16'h0020);      wait_done();
    issue(16'h0100, 16'h0100);      wait_done();
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    bus.start = 1'b1; bus.multiplicand = 16'hAAAA; bus.multiplier = 16'h5555;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_product", bus.product, 0);
    prod_hold = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(16'd2, 16'd2);            wait_done();
    repeat (2) @(negedge clk);

    // Random operations with corner operands mixed in and random gaps (0 = back-to-back).
    for (int i = 0; i < 25; i++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      case ($urandom_range(0, 5))
        0: rm = '1;
        1: rq = '1;
        2: rm = '0;
        3: rq = '0;
        default: ;
      endcase
      issue(rm, rq);
      wait_done();
      gap = $urandom_range(0, 3);
      if (gap > 0) repeat (gap) @(negedge clk);
    end

    repeat (W + 4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("done_count", done_cnt, issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
